// File: rtl/ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch
// Instruction fetch stage for the LEGv8 pipeline. It owns the fetch PC, keeps
// at most one read outstanding to a variable-latency instruction memory, and
// buffers returned words with their PC in a DEPTH-entry prefetch FIFO. The
// FIFO head is handed downstream over a valid/ready handshake. A taken-branch
// redirect flushes the FIFO and restarts fetch at the new address.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   mem_req, mem_addr    registered read request / word-aligned byte address
//   mem_ack, mem_rdata   memory response strobe and returned instruction word
//   redirect_en/_pc      branch-taken restart request and target address
//   inst_valid/_ready    downstream handshake for the FIFO head
//   instruction, inst_pc FIFO head word and its PC (registered)
//   fetch_fault          only with IFETCH_ALIGN_CHECK_EN: sticky misaligned
//                        redirect flag; once set, no further requests issue
//
// Build option: define IFETCH_ALIGN_CHECK_EN to enable the alignment check.
// Without it, redirect_pc[1:0] is ignored (treated as 0).
// ---------------------------------------------------------------------------
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [63:0] inst_pc
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fifo_entry_t;

  state_t            state_q, state_d;
  logic [63:0]       fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       instruction_q, instruction_d;
  logic [63:0]       inst_pc_q, inst_pc_d;
  fifo_entry_t       fifo_q [DEPTH];

  logic [63:0]       redirect_pc_w;
  logic              block_w;
  logic              pop_w;
  logic              push_w;
  logic              issue_idle_w;
  logic              rerequest_w;
  logic [63:0]       fetch_pc_inc_w;
  fifo_entry_t       push_entry_w;
  fifo_entry_t       head_w;

  // Alignment handling: either a sticky fault that stops fetch, or silent masking.
`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic fault_set_w;

  assign redirect_pc_w = redirect_pc;
  assign fault_set_w   = redirect_en & (redirect_pc[1:0] != 2'b00);
  assign fault_d       = fault_q | fault_set_w;
  assign block_w       = fault_q | fault_set_w;
  assign fetch_fault   = fault_q;

  always_ff @(posedge clock) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`else
  assign redirect_pc_w = redirect_pc & ~64'h3;
  assign block_w       = 1'b0;
`endif

  // Handshake qualifiers; a redirect overrides both push and pop.
  assign pop_w          = inst_valid_q & inst_ready & ~redirect_en;
  assign push_w         = (state_q == S_WAIT) & mem_ack & ~redirect_en;
  assign issue_idle_w   = (count_q < CNT_W'(DEPTH)) & ~redirect_en & ~block_w;
  // After a push, room remains if the FIFO was below DEPTH-1 or a pop frees a slot.
  assign rerequest_w    = ((count_q < CNT_W'(DEPTH - 1)) | pop_w) & ~block_w;
  assign fetch_pc_inc_w = fetch_pc_q + 64'd4;
  assign push_entry_w   = '{instr: mem_rdata, pc: fetch_pc_q};

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue_idle_w) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = (push_w && rerequest_w) ? S_WAIT : S_IDLE;
        end else if (redirect_en) begin
          // The request cannot be withdrawn; swallow its response later.
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request line, request address and fetch PC
  always_comb begin
    mem_req_d  = (state_d != S_IDLE);
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc_w;
    end else if (push_w) begin
      fetch_pc_d = fetch_pc_inc_w;
    end
    if ((state_q == S_IDLE) && (state_d == S_WAIT)) begin
      mem_addr_d = fetch_pc_q;
    end else if (push_w && (state_d == S_WAIT)) begin
      mem_addr_d = fetch_pc_inc_w;
    end
  end

  // FIFO pointers, occupancy and registered head
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inst_valid_d  = inst_valid_q;
    instruction_d = instruction_q;
    inst_pc_d     = inst_pc_q;
    head_w        = fifo_q[rd_ptr_q];
    if (redirect_en) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      inst_valid_d = 1'b0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // The entry being written this edge is not in storage yet; forward it.
      if (push_w && (wr_ptr_q == rd_ptr_d)) head_w = push_entry_w;
      else                                   head_w = fifo_q[rd_ptr_d];
      inst_valid_d = (count_d != '0);
      if (count_d != '0) begin
        instruction_d = head_w.instr;
        inst_pc_d     = head_w.pc;
      end
    end
  end

  // Datapath and control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inst_valid_q  <= 1'b0;
      instruction_q <= '0;
      inst_pc_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inst_valid_q  <= inst_valid_d;
      instruction_q <= instruction_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clock) begin
    if (push_w) fifo_q[wr_ptr_q] <= push_entry_w;
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign inst_valid  = inst_valid_q;
  assign instruction = instruction_q;
  assign inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch_prefetch
// Directed bench for ifetch_prefetch (DEPTH=4, RESET_PC=0x100). A small
// memory responder acks each request after a programmable number of cycles
// and returns addr[31:0] ^ 0xDEAD0000 as the instruction word.
// ---------------------------------------------------------------------------
module tb_ifetch_prefetch;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int errors = 0;
  int checks = 0;
  int lat    = 0;

  ifetch_prefetch #(
    .DEPTH    (4),
    .RESET_PC (64'h100)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory responder: ack after 'lat' idle cycles of a pending request.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (mem_req) begin
        if (cnt == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr[31:0] ^ 32'hDEAD_0000;
          cnt       = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt     = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold reset over two edges; returns at a negedge with reset still high.
  task automatic apply_reset(input int l, input logic rdy);
    reset       = 1'b1;
    lat         = l;
    inst_ready  = rdy;
    redirect_en = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [63:0] exp_pc;
    int          seen;

    // ---- 1: reset values, then streaming with ack tied to req ----
    apply_reset(0, 1'b0);
    check("rst_mem_req",    64'(mem_req), 64'd0);
    check("rst_mem_addr",   mem_addr, 64'h100);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_instr",      64'(instruction), 64'd0);
    check("rst_inst_pc",    inst_pc, 64'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("rst_fault",      64'(fetch_fault), 64'd0);
`endif
    reset      = 1'b0;
    inst_ready = 1'b1;
    @(negedge clock);
    check("t1_first_req",   64'(mem_req), 64'd1);
    check("t1_first_addr",  mem_addr, 64'h100);
    check("t1_no_bypass",   64'(inst_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("t1_inst_pc", inst_pc, 64'h100 + 64'(4 * k));
      check("t1_instr",   64'(instruction), 64'(32'hDEAD_0100 + 32'(4 * k)));
      check("t1_addr",    mem_addr, 64'h104 + 64'(4 * k));
    end

    // ---- 2: consumer stalled, latency 1 -> exactly four words buffered ----
    apply_reset(1, 1'b0);
    reset = 1'b0;
    repeat (14) @(negedge clock);
    check("t2_full_no_req", 64'(mem_req), 64'd0);
    check("t2_full_valid",  64'(inst_valid), 64'd1);
    check("t2_full_head",   inst_pc, 64'h100);
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
    check("t2_pop_head",    inst_pc, 64'h104);
    check("t2_pop_no_req",  64'(mem_req), 64'd0);
    @(negedge clock);
    check("t2_refill_req",  64'(mem_req), 64'd1);
    check("t2_refill_addr", mem_addr, 64'h110);
    repeat (3) @(negedge clock);
    check("t2_full_again",  64'(mem_req), 64'd0);
    check("t2_head_held",   inst_pc, 64'h104);

    // ---- 3: redirect during a slow request -> DISCARD then refetch ----
    apply_reset(3, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("t3_req",          64'(mem_req), 64'd1);
    redirect_en = 1'b1;
    redirect_pc = 64'h400;
    @(negedge clock);
    redirect_en = 1'b0;
    check("t3_req_held",     64'(mem_req), 64'd1);
    check("t3_addr_held",    mem_addr, 64'h100);
    check("t3_no_valid_a",   64'(inst_valid), 64'd0);
    repeat (3) @(negedge clock);
    check("t3_discard_done", 64'(mem_req), 64'd0);
    check("t3_late_dropped", 64'(inst_valid), 64'd0);
    @(negedge clock);
    check("t3_new_req",      64'(mem_req), 64'd1);
    check("t3_new_addr",     mem_addr, 64'h400);
    repeat (4) @(negedge clock);
    check("t3_valid",        64'(inst_valid), 64'd1);
    check("t3_pc",           inst_pc, 64'h400);
    check("t3_instr",        64'(instruction), 64'hDEAD_0400);

    // ---- 4: redirect coincides with ack and a pop ----
    apply_reset(0, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("t4_head",       inst_pc, 64'h100);
    redirect_en = 1'b1;
    redirect_pc = 64'h800;
    @(negedge clock);
    redirect_en = 1'b0;
    check("t4_flushed",    64'(inst_valid), 64'd0);
    check("t4_req_drop",   64'(mem_req), 64'd0);
    @(negedge clock);
    check("t4_new_addr",   mem_addr, 64'h800);
    check("t4_new_req",    64'(mem_req), 64'd1);
    @(negedge clock);
    check("t4_valid",      64'(inst_valid), 64'd1);
    check("t4_pc",         inst_pc, 64'h800);
    check("t4_instr",      64'(instruction), 64'hDEAD_0800);

    // ---- 5: push and pop together at count=3, ordering across wrap ----
    apply_reset(1, 1'b0);
    reset = 1'b0;
    repeat (14) @(negedge clock);
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
    @(negedge clock);
    check("t5_req_addr",   mem_addr, 64'h110);
    @(negedge clock);
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
    check("t5_head",       inst_pc, 64'h108);
    check("t5_rereq",      64'(mem_req), 64'd1);
    check("t5_rereq_addr", mem_addr, 64'h114);
    repeat (2) @(negedge clock);
    check("t5_full",       64'(mem_req), 64'd0);
    inst_ready = 1'b1;
    exp_pc     = 64'h108;
    seen       = 0;
    for (int i = 0; i < 40 && seen < 8; i++) begin
      if (inst_valid) begin
        check("t5_order_pc",    inst_pc, exp_pc);
        check("t5_order_instr", 64'(instruction), 64'(exp_pc[31:0] ^ 32'hDEAD_0000));
        exp_pc += 64'd4;
        seen++;
      end
      @(negedge clock);
    end
    check("t5_drain_count", 64'(seen), 64'd8);
    inst_ready = 1'b0;

    // ---- 6: misaligned redirect ----
    apply_reset(0, 1'b0);
    reset       = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 64'h402;
    @(negedge clock);
    redirect_en = 1'b0;
    check("t6_idle", 64'(mem_req), 64'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("t6_fault", 64'(fetch_fault), 64'd1);
    repeat (5) @(negedge clock);
    check("t6_blocked",     64'(mem_req), 64'd0);
    check("t6_fault_stick", 64'(fetch_fault), 64'd1);
    check("t6_no_valid",    64'(inst_valid), 64'd0);
`else
    @(negedge clock);
    check("t6_req",   64'(mem_req), 64'd1);
    check("t6_addr",  mem_addr, 64'h400);
    @(negedge clock);
    check("t6_valid", 64'(inst_valid), 64'd1);
    check("t6_pc",    inst_pc, 64'h400);
    check("t6_instr", 64'(instruction), 64'hDEAD_0400);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
